// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS datapath.
//   WORD_W    : datapath word width in bits
//   DM_ADDR_W : data-memory byte-address width (1 KiB)
//   word_t    : one datapath word
package mips_pkg;

    localparam int WORD_W    = 32;
    localparam int DM_ADDR_W = 10;

    typedef logic [WORD_W-1:0] word_t;

endpackage : mips_pkg

// File: rtl/dm_1k_ram.sv
// dm_1k_ram - 1 KiB data memory for the single-cycle MIPS datapath.
// Byte-addressed, word-organised (2**(ADDR_W-2) words of DATA_W bits).
// Asynchronous read, synchronous write, synchronous clear of the whole array.
//
// Ports (legacy positional order: addr, din, we, clk, dout, reset):
//   addr   in  ADDR_W  byte address; addr[ADDR_W-1:2] selects the word,
//                      addr[1:0] is ignored (misaligned = aligned word)
//   din    in  DATA_W  write data (rt for sw)
//   we     in  1       write enable, sampled on the rising edge of clk
//   clk    in  1       rising-edge clock
//   dout   out DATA_W  read data, combinational from addr and contents
//   reset  in  1       synchronous active-high; clears every word, wins over we
module dm_1k_ram
    import mips_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = WORD_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              we,
    input  logic              clk,
    output logic [DATA_W-1:0] dout,
    input  logic              reset
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-3:0] idx;

    assign idx = addr[ADDR_W-1:2];

    // Byte-lane bits play no part in a word memory.
    logic unused_byte_lane;
    assign unused_byte_lane = ^addr[1:0];

    // NOTE: this array is cleared by reset, so it maps to registers rather
    // than a RAM macro; a memory that needs no clear should not be reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= din;
        end
    end

    // Zero-latency read: a write becomes visible right after its edge.
    assign dout = mem[idx];

    // An unknown write enable could corrupt an arbitrary word in silicon.
    we_known_a: assert property (@(posedge clk) !$isunknown(we));

endmodule : dm_1k_ram

// File: tb/tb_dm_1k_ram.sv
// Directed and randomised checks of dm_1k_ram against hand-computed values
// and a reference array.
module tb_dm_1k_ram;

    logic [9:0]  addr;
    logic [31:0] din;
    logic        we;
    logic        clk;
    logic [31:0] dout;
    logic        reset;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [256];

    dm_1k_ram dut (
        .addr  (addr),
        .din   (din),
        .we    (we),
        .clk   (clk),
        .dout  (dout),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge; inputs are then changed 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input logic [9:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL %s: addr=%h dout=%h expected=%h", name, a, dout, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        we    = 1'b0;
        addr  = '0;
        din   = '0;
        tick();
        reset = 1'b0;
        for (int w = 0; w < 256; w++) begin
            read_check(10'(w * 4), 32'h0, "reset_clear");
        end
    endtask

    task automatic test_misaligned_write();
        addr = 10'h001;
        din  = 32'h0000_0100;
        we   = 1'b1;
        tick();
        we = 1'b0;
        for (int b = 0; b < 4; b++) begin
            read_check(10'(b), 32'h0000_0100, "misaligned_write");
        end
    endtask

    task automatic test_write_disable();
        addr = 10'h000;
        din  = 32'hDEAD_BEEF;
        we   = 1'b0;
        tick();
        read_check(10'h000, 32'h0000_0100, "we_low_word0");
        read_check(10'h004, 32'h0000_0000, "we_low_word1");
    endtask

    task automatic test_wrap_no_alias();
        addr = 10'h3FC;
        din  = 32'hA5A5_A5A5;
        we   = 1'b1;
        tick();
        addr = 10'h000;
        din  = 32'h5A5A_5A5A;
        tick();
        we = 1'b0;
        read_check(10'h3FC, 32'hA5A5_A5A5, "word255");
        read_check(10'h3FF, 32'hA5A5_A5A5, "word255_top_byte");
        read_check(10'h000, 32'h5A5A_5A5A, "word0");
    endtask

    task automatic test_back_to_back();
        addr = 10'h010;
        din  = 32'h1111_1111;
        we   = 1'b1;
        tick();
        // Same word, same-cycle read: old value until the edge, new after it.
        din = 32'h2222_2222;
        #1;
        checks++;
        if (dout !== 32'h1111_1111) begin
            errors++;
            $display("FAIL b2b_pre_edge: dout=%h expected=%h", dout, 32'h1111_1111);
        end
        tick();
        we = 1'b0;
        read_check(10'h010, 32'h2222_2222, "b2b_last_wins");
    endtask

    task automatic test_reset_wins();
        addr  = 10'h008;
        din   = 32'hFFFF_FFFF;
        we    = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        we    = 1'b0;
        read_check(10'h008, 32'h0, "reset_over_we");
        read_check(10'h000, 32'h0, "reset_clears_word0");
        read_check(10'h3FC, 32'h0, "reset_clears_word255");
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic [9:0]  a;
            logic [31:0] d;
            logic        w;
            logic        r;
            a = 10'($urandom_range(0, 1023));
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 99) < 2);
            din   = d;
            we    = w;
            reset = r;
            read_check(a, model[a[9:2]], "rand_pre_edge");
            @(posedge clk);
            if (r) begin
                for (int i = 0; i < 256; i++) model[i] = 32'h0;
            end else if (w) begin
                model[a[9:2]] = d;
            end
            #1;
            checks++;
            if (dout !== model[a[9:2]]) begin
                errors++;
                $display("FAIL rand_post_edge: cyc=%0d addr=%h dout=%h expected=%h",
                         cyc, a, dout, model[a[9:2]]);
            end
        end
        reset = 1'b0;
        we    = 1'b0;
    endtask

    initial begin
        addr  = '0;
        din   = '0;
        we    = 1'b0;
        reset = 1'b0;
        #2;
        test_reset();
        test_misaligned_write();
        test_write_disable();
        test_wrap_no_alias();
        test_back_to_back();
        test_reset_wins();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dm_1k_ram
